// File: rtl/mult_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit_pkg
// Brief    : Shared MDU op encodings and default latencies (decoder + MDU).
// Revision : 1.0 - initial release
// ============================================================================
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MDU_READ_HI            = 3'd0,
        MDU_READ_LO            = 3'd1,
        MDU_WRITE_HI           = 3'd2,
        MDU_WRITE_LO           = 3'd3,
        MDU_START_SIGNED_MUL   = 3'd4,
        MDU_START_UNSIGNED_MUL = 3'd5,
        MDU_START_SIGNED_DIV   = 3'd6,
        MDU_START_UNSIGNED_DIV = 3'd7
    } mdu_op_t;

    localparam int C_MUL_CYCLES = 5;
    localparam int C_DIV_CYCLES = 10;

endpackage
`default_nettype wire

// File: rtl/mult_div_unit_mdu_compute.sv
`default_nettype none
// ============================================================================
// Module   : mdu_compute
// Brief    : Combinational 64-bit {HI,LO} result for MULT/MULTU/DIV/DIVU.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_compute
    import mult_div_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    output logic [63:0] hilo
);

    logic        w_signed;
    logic [63:0] w_ext1;
    logic [63:0] w_ext2;
    logic [63:0] w_prod;
    logic        w_neg1;
    logic        w_neg2;
    logic [31:0] w_mag1;
    logic [31:0] w_mag2;
    logic [31:0] w_den;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    always_comb begin
        w_signed = (op == MDU_START_SIGNED_MUL) || (op == MDU_START_SIGNED_DIV);
        w_ext1   = w_signed ? {{32{operand1[31]}}, operand1} : {32'd0, operand1};
        w_ext2   = w_signed ? {{32{operand2[31]}}, operand2} : {32'd0, operand2};
        // Low 64 bits of the extended product are exact for both signednesses.
        w_prod   = w_ext1 * w_ext2;

        // Signed division via magnitudes; 0x80000000 / -1 naturally yields
        // quotient 0x80000000 and remainder 0.
        w_neg1   = w_signed & operand1[31];
        w_neg2   = w_signed & operand2[31];
        w_mag1   = w_neg1 ? (32'd0 - operand1) : operand1;
        w_mag2   = w_neg2 ? (32'd0 - operand2) : operand2;
        w_den    = (w_mag2 == 32'd0) ? 32'd1 : w_mag2;
        w_q      = w_mag1 / w_den;
        w_r      = w_mag1 % w_den;
        w_quo    = (w_neg1 ^ w_neg2) ? (32'd0 - w_q) : w_q;
        w_rem    = w_neg1 ? (32'd0 - w_r) : w_r;

        hilo = 64'd0;
        case (op)
            MDU_START_SIGNED_MUL,
            MDU_START_UNSIGNED_MUL: hilo = w_prod;
            MDU_START_SIGNED_DIV,
            MDU_START_UNSIGNED_DIV: hilo = (operand2 == 32'd0) ?
                                           {operand1, 32'hFFFF_FFFF} :
                                           {w_rem, w_quo};
            default:                hilo = 64'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Brief    : EX-stage multiply/divide unit owning HI/LO with fixed latency.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MUL_CYCLES = C_MUL_CYCLES,
    parameter int DIV_CYCLES = C_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdu_use,
    input  logic [2:0]  mdu_op,
    input  logic        mdu_start,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    output logic        busy,
    output logic [31:0] result
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic [63:0]      r_shadow;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic [63:0]      w_hilo;
    logic             w_is_div;
    logic [CNT_W-1:0] w_load;

    mdu_compute u_compute (
        .op       (mdu_op),
        .operand1 (operand1),
        .operand2 (operand2),
        .hilo     (w_hilo)
    );

    assign w_is_div = (mdu_op == MDU_START_SIGNED_DIV) || (mdu_op == MDU_START_UNSIGNED_DIV);
    assign w_load   = w_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_shadow <= 64'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (mdu_use) begin
                        if (mdu_start) begin
                            r_shadow <= w_hilo;
                            r_count  <= w_load;
                            r_state  <= ST_RUN;
                        end else if (mdu_op == MDU_WRITE_HI) begin
                            r_hi <= operand1;
                        end else if (mdu_op == MDU_WRITE_LO) begin
                            r_lo <= operand1;
                        end
                    end
                end
                ST_RUN: begin
                    // Requests arriving while running are ignored; the pipeline stalls them.
                    if (r_count == '0) begin
                        r_hi    <= r_shadow[63:32];
                        r_lo    <= r_shadow[31:0];
                        r_state <= ST_IDLE;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (r_state == ST_RUN);

    always_comb begin
        result = 32'd0;
        if (mdu_op == MDU_READ_HI) begin
            result = r_hi;
        end else if (mdu_op == MDU_READ_LO) begin
            result = r_lo;
        end
    end

endmodule
`default_nettype wire
